// File: rtl/pulse_sync_arbiter_pkg.sv
// Shared types and sizing helpers for the pulse-synchronizer scheduler.
package pulse_sync_pkg;
  localparam int NREQ_MAX = 8;

  typedef enum logic [1:0] {IDLE, STROBE, SETTLE} state_t;

  // $clog2 with a floor of 1 so single-value ranges still get a real bit.
  function automatic int clog2w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int maxi(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/pulse_sync_arbiter_if.sv
// Requester-side bundle of the pulse-synchronizer scheduler.
interface pulse_sync_arbiter_if #(
  parameter int N    = 8,
  parameter int NREQ = 4
);
  localparam int IDW = pulse_sync_pkg::clog2w(NREQ);

  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [IDW-1:0]    gnt_id;
  logic              stb_o;
  logic [N-1:0]      data_o;

  modport master (output req, req_data,
                  input  gnt, done, busy, gnt_id, stb_o, data_o);
  modport slave  (input  req, req_data,
                  output gnt, done, busy, gnt_id, stb_o, data_o);
endinterface

// File: rtl/pulse_sync_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_arbiter
  import pulse_sync_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = clog2w(NREQ)
)(
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id,
  output logic            any
);
  logic [IDW-1:0] idx;

  // Scan farthest-first so the candidate nearest ptr overwrites the rest.
  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        id  = idx;
        any = 1'b1;
      end
    end
    for (int j = 0; j < NREQ; j++) gnt[j] = any && (id == IDW'(j));
  end
endmodule

// File: rtl/pulse_sync_arbiter.sv
// Shares one strobe/data synchronizer channel among NREQ requesters.
module pulse_sync_arbiter
  import pulse_sync_pkg::*;
#(
  parameter int N       = 8,
  parameter int NREQ    = 4,
  parameter int STB_CYC = 4,
  parameter int GAP_CYC = 4
)(
  input logic clk,
  input logic rst_n,
  input logic ena,
  pulse_sync_arbiter_if.slave bus
);
  localparam int IDW = clog2w(NREQ);
  localparam int CW  = clog2w(maxi(STB_CYC, GAP_CYC) + 1);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [IDW-1:0] ptr, gnt_id_q, arb_id;
  logic [NREQ-1:0] arb_gnt, gnt_oh;
  logic           arb_any, grant_fire;
  logic [N-1:0]   data_q, win_data;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req (bus.req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .id  (arb_id),
    .any (arb_any)
  );

  assign grant_fire = ena && (state == IDLE) && arb_any;

  always_comb begin
    win_data = '0;
    for (int k = 0; k < NREQ; k++)
      if (arb_gnt[k]) win_data = bus.req_data[k*N +: N];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ena low freezes everything, which is what stretches the strobe.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (ena) begin
      case (state)
        IDLE: if (arb_any) begin
          state_nxt = STROBE;
          cnt_nxt   = CW'(STB_CYC - 1);
        end
        STROBE: if (cnt == '0) begin
          state_nxt = SETTLE;
          cnt_nxt   = CW'(GAP_CYC - 1);
        end else cnt_nxt = cnt - CW'(1);
        SETTLE: if (cnt == '0) state_nxt = IDLE;
                else cnt_nxt = cnt - CW'(1);
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Word, id and pointer move only on a grant edge; data_o holds afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      gnt_id_q <= '0;
      data_q   <= '0;
    end else if (grant_fire) begin
      data_q   <= win_data;
      gnt_id_q <= arb_id;
      ptr      <= (arb_id == IDW'(NREQ - 1)) ? '0 : arb_id + IDW'(1);
    end
  end

  always_comb begin
    gnt_oh = '0;
    for (int k = 0; k < NREQ; k++) gnt_oh[k] = (gnt_id_q == IDW'(k));
    bus.busy  = (state != IDLE);
    bus.stb_o = (state == STROBE);
    bus.gnt   = (state != IDLE) ? gnt_oh : '0;
    bus.done  = (state == SETTLE && cnt == '0 && ena) ? gnt_oh : '0;
  end

  assign bus.gnt_id = gnt_id_q;
  assign bus.data_o = data_q;
endmodule

// File: tb/tb_pulse_sync_arbiter.sv
// Scoreboard bench: transfer-level model predicts grants, monitor checks outputs.
module tb_pulse_sync_arbiter;
  localparam int N = 8, NREQ = 4, STB = 4, GAP = 4;
  localparam int DW = NREQ * N;

  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, ena2 = 1'b1;
  always #5 clk = ~clk;

  pulse_sync_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();
  pulse_sync_arbiter_if #(.N(N), .NREQ(2))    bus2 ();

  pulse_sync_arbiter #(.N(N), .NREQ(NREQ), .STB_CYC(STB), .GAP_CYC(GAP)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus.slave));
  pulse_sync_arbiter #(.N(N), .NREQ(2), .STB_CYC(1), .GAP_CYC(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena2), .bus(bus2.slave));

  int nchk = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one transfer = STB+GAP enabled cycles
  typedef struct { int id; logic [N-1:0] data; } xfer_t;
  xfer_t exp_q[$];
  int m_rem, m_ptr;

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int j = (p + k) % NREQ;
      if (((r >> j) & NREQ'(1)) != '0) return j;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] word_of(input logic [DW-1:0] d, input int i);
    return N'(d >> (i * N));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0;
      m_ptr <= 0;
      exp_q.delete();
    end else if (ena) begin
      if (m_rem > 0) m_rem <= m_rem - 1;
      else if (bus.req != '0) begin
        exp_q.push_back('{id: rr_pick(bus.req, m_ptr),
                          data: word_of(bus.req_data, rr_pick(bus.req, m_ptr))});
        m_ptr <= (rr_pick(bus.req, m_ptr) + 1) % NREQ;
        m_rem <= STB + GAP;
      end
    end
  end

  // ---------------- monitor
  initial begin
    xfer_t cur;
    bit inflight = 0, prev_stb = 0;
    int sn = 0, gn = 0;
    cur = '{id: 0, data: '0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inflight = 0;
        prev_stb = 0;
      end else begin
        if (bus.stb_o && !prev_stb) begin
          if (exp_q.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL sb_stb_unexpected: strobe rose with id %0d, none predicted at %0t",
                     bus.gnt_id, $time);
          end else begin
            cur = exp_q.pop_front();
            chk("sb_gnt_id", 32'(bus.gnt_id), 32'(cur.id));
            chk("sb_data", 32'(bus.data_o), 32'(cur.data));
            chk("sb_gnt", 32'(bus.gnt), 32'(1) << cur.id);
            inflight = 1; sn = 0; gn = 0;
          end
        end
        if (inflight) begin
          chk("sb_data_hold", 32'(bus.data_o), 32'(cur.data));
          if (bus.stb_o && ena) sn++;
          if (!bus.stb_o && prev_stb) chk("sb_stb_width", 32'(sn), 32'(STB));
          if (!bus.stb_o && ena) gn++;
        end
        if (bus.done != '0) begin
          chk("sb_done", 32'(bus.done), inflight ? (32'(1) << cur.id) : 32'(0));
          if (inflight) chk("sb_gap", 32'(gn), 32'(GAP));
          inflight = 0;
        end
        if (!ena) chk("sb_done_frozen", 32'(bus.done), 32'(0));
        chk("sb_gnt_busy", 32'(bus.gnt != '0), 32'(bus.busy));
        chk("sb_gnt_onehot", 32'($onehot0(bus.gnt)), 32'(1));
        prev_stb = bus.stb_o;
      end
    end
  end

  // ---------------- directed helpers
  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b1;
    bus.req = '0; bus2.req = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Requester drops req right after grant and scrambles words; expects fixed timeline.
  task automatic tl(input string tag, input int ncyc, input int stb_hi, input int done_c,
                    input logic [NREQ-1:0] gv, input int busy_hi, input logic [N-1:0] dval,
                    input int ena_from, input int ena_to);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.req = '0;
      if (c == 2) bus.req_data = DW'($urandom);
      ena = !(c >= ena_from && c <= ena_to);
      #1;
      if (c == 1) chk({tag, "_gnt"}, 32'(bus.gnt), 32'(gv));
      chk({tag, "_stb"}, 32'(bus.stb_o), 32'(c <= stb_hi));
      chk({tag, "_done"}, 32'(bus.done), (c == done_c) ? 32'(gv) : 32'(0));
      chk({tag, "_busy"}, 32'(bus.busy), 32'(c <= busy_hi));
      chk({tag, "_data"}, 32'(bus.data_o), 32'(dval));
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nr, last;
    bit pv;
    logic [NREQ-1:0] tg;
    bus.req = '0; bus.req_data = '0; bus2.req = '0; bus2.req_data = '0;
    #2;
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_gnt_id", 32'(bus.gnt_id), 0);
    chk("rst_stb", 32'(bus.stb_o), 0);
    chk("rst_data", 32'(bus.data_o), 0);

    // single requester, basic timeline
    do_reset();
    bus.req = 4'b0001; bus.req_data = 32'h000000A5;
    tl("t1", 10, 4, 8, 4'b0001, 8, 8'hA5, 0, -1);

    // req/data changes after grant ignored
    do_reset();
    bus.req = 4'b0100; bus.req_data = 32'h00770000;
    tl("t3", 10, 4, 8, 4'b0100, 8, 8'h77, 0, -1);

    // ena low 3 cycles during STROBE stretches strobe and done
    do_reset();
    bus.req = 4'b0001; bus.req_data = 32'h0000005A;
    tl("t4", 13, 7, 11, 4'b0001, 11, 8'h5A, 2, 4);

    // all requesting: rotation 0,1,2,3,0 with 9-cycle spacing
    do_reset();
    bus.req = 4'b1111; bus.req_data = 32'h44332211;
    nr = 0; last = 0; pv = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #2;
      if (bus.stb_o && !pv) begin
        chk("t2_id", 32'(bus.gnt_id), 32'(nr % 4));
        chk("t2_data", 32'(bus.data_o), 32'(8'h11) * 32'(nr % 4 + 1));
        if (nr > 0) chk("t2_spacing", 32'(c - last), 32'(9));
        last = c; nr++;
      end
      pv = bus.stb_o;
    end
    chk("t2_count", 32'(nr), 32'(5));
    bus.req = '0;
    repeat (10) @(posedge clk);

    // reset during SETTLE abandons transfer; priority restarts at 0
    do_reset();
    bus.req = 4'b0001; bus.req_data = 32'h000000C3;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.req = '0;
    end
    rst_n = 1'b0;
    #1;
    chk("t5_stb", 32'(bus.stb_o), 0);
    chk("t5_data", 32'(bus.data_o), 0);
    chk("t5_gnt", 32'(bus.gnt), 0);
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_done", 32'(bus.done), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.req = 4'b0011; bus.req_data = 32'h0000BBAA;
    @(posedge clk); #2;
    chk("t5_first_id", 32'(bus.gnt_id), 0);
    chk("t5_first_gnt", 32'(bus.gnt), 32'(4'b0001));
    bus.req = 4'b0010;
    repeat (9) @(posedge clk);
    #1;
    chk("t5_next_id", 32'(bus.gnt_id), 1);
    chk("t5_next_stb", 32'(bus.stb_o), 1);
    bus.req = '0;
    repeat (12) @(posedge clk);

    // NREQ=2, 1-cycle strobe and gap: pulses every 3 cycles, alternating
    do_reset();
    bus2.req = 2'b11; bus2.req_data = 16'hBBAA;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #2;
      chk("t6_stb", 32'(bus2.stb_o), 32'(c % 3 == 1));
      if (c % 3 == 1) begin
        chk("t6_id", 32'(bus2.gnt_id), 32'(((c - 1) / 3) % 2));
        chk("t6_data", 32'(bus2.data_o), (((c - 1) / 3) % 2) ? 32'hBB : 32'hAA);
      end
    end
    bus2.req = '0;

    // randomized traffic with ena gaps, checked by model + monitor
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      tg = NREQ'($urandom) & NREQ'($urandom) & NREQ'($urandom);
      bus.req = bus.req ^ tg;
      if ($urandom_range(0, 1) == 1) bus.req_data = DW'($urandom);
      ena = ($urandom_range(0, 9) != 0);
    end
    bus.req = '0; ena = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("drain_queue", 32'(exp_q.size()), 0);
    chk("drain_busy", 32'(bus.busy), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
